// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multi-cycle MIPS control unit:
//               opcodes, funct codes, ALU control codes, FSM state codes and
//               datapath mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    // ALU operation class handed to the ALU control decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // FSM state encodings (visible on the debug state port)
    localparam int unsigned c_STATE_W = 4;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH     = 4'd0;
    localparam logic [c_STATE_W-1:0] c_ST_DECODE    = 4'd1;
    localparam logic [c_STATE_W-1:0] c_ST_MEM_ADDR  = 4'd2;
    localparam logic [c_STATE_W-1:0] c_ST_MEM_READ  = 4'd3;
    localparam logic [c_STATE_W-1:0] c_ST_MEM_WB    = 4'd4;
    localparam logic [c_STATE_W-1:0] c_ST_MEM_WRITE = 4'd5;
    localparam logic [c_STATE_W-1:0] c_ST_EXECUTE   = 4'd6;
    localparam logic [c_STATE_W-1:0] c_ST_R_WB      = 4'd7;
    localparam logic [c_STATE_W-1:0] c_ST_BRANCH    = 4'd8;
    localparam logic [c_STATE_W-1:0] c_ST_JUMP      = 4'd9;
    localparam logic [c_STATE_W-1:0] c_ST_ADDI_EX   = 4'd10;
    localparam logic [c_STATE_W-1:0] c_ST_ADDI_WB   = 4'd11;
    localparam logic [c_STATE_W-1:0] c_ST_TRAP      = 4'd12;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    // States that wait on the memory handshake
    function automatic logic is_mem_state(input logic [c_STATE_W-1:0] st);
        return (st == c_ST_FETCH) || (st == c_ST_MEM_READ) || (st == c_ST_MEM_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_decoder
// Description : Combinational ALU control decode. Fixed ADD/SUB for address
//               and compare work, funct-driven operation for R-type execute.
//               funct_valid flags the supported R-type funct codes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    logic [3:0] w_funct_alu;

    // Map the R-type funct field onto an ALU operation
    always_comb begin
        w_funct_alu = c_ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            c_FN_ADD: w_funct_alu = c_ALU_ADD;
            c_FN_SUB: w_funct_alu = c_ALU_SUB;
            c_FN_AND: w_funct_alu = c_ALU_AND;
            c_FN_OR:  w_funct_alu = c_ALU_OR;
            c_FN_SLT: w_funct_alu = c_ALU_SLT;
            default: begin
                w_funct_alu = c_ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

    // Select between the fixed operations and the funct-driven one
    always_comb begin
        alu_control = c_ALU_ADD;
        case (alu_op)
            c_ALUOP_ADD:   alu_control = c_ALU_ADD;
            c_ALUOP_SUB:   alu_control = c_ALU_SUB;
            c_ALUOP_FUNCT: alu_control = w_funct_alu;
            default:       alu_control = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multi-cycle MIPS datapath. Sequences
//               memory, IR, register file, ALU and PC; stretches memory
//               states on mem_ready; counts retired instructions and traps
//               unsupported encodings or memory stalls beyond WAIT_LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int WAIT_LIMIT  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   mem_to_reg,
    output logic                   reg_dst,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [3:0]             alu_control,
    output logic                   error,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    // Wait counter only needs to reach WAIT_LIMIT, where it saturates
    localparam int c_wait_w = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(WAIT_LIMIT);

    logic [c_STATE_W-1:0]   r_state;
    logic [c_STATE_W-1:0]   w_next;
    logic [c_wait_w-1:0]    r_wait;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_error;
    logic                   w_wait_expired;
    logic                   w_funct_valid;
    logic [3:0]             w_dec_alu;
    logic [1:0]             w_alu_op;
    logic                   w_alu_en;

    // Unregated enables, masked by reset before reaching the ports
    logic w_pc_write;
    logic w_pc_write_cond;
    logic w_mem_read;
    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;

    // ZERO zero flag is consumed by the datapath PC-write qualifier, not here
    logic w_unused;
    assign w_unused = zero;

    alu_control_decoder u_alu_dec (
        .alu_op      (w_alu_op),
        .funct       (funct),
        .alu_control (w_dec_alu),
        .funct_valid (w_funct_valid)
    );

    generate
        if (WAIT_LIMIT != 0) begin : g_wait_limit
            assign w_wait_expired = (r_wait == c_wait_max) && !mem_ready;
        end else begin : g_no_wait_limit
            assign w_wait_expired = 1'b0;
        end
    endgenerate

    // Next-state selection from the registered state and decoded IR fields
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (mem_ready)           w_next = c_ST_DECODE;
                else if (w_wait_expired) w_next = c_ST_TRAP;
            end
            c_ST_DECODE: begin
                case (opcode)
                    c_OP_RTYPE: w_next = w_funct_valid ? c_ST_EXECUTE : c_ST_TRAP;
                    c_OP_LW:    w_next = c_ST_MEM_ADDR;
                    c_OP_SW:    w_next = c_ST_MEM_ADDR;
                    c_OP_BEQ:   w_next = c_ST_BRANCH;
                    c_OP_J:     w_next = c_ST_JUMP;
                    c_OP_ADDI:  w_next = c_ST_ADDI_EX;
                    default:    w_next = c_ST_TRAP;
                endcase
            end
            c_ST_MEM_ADDR: w_next = (opcode == c_OP_LW) ? c_ST_MEM_READ : c_ST_MEM_WRITE;
            c_ST_MEM_READ: begin
                if (mem_ready)           w_next = c_ST_MEM_WB;
                else if (w_wait_expired) w_next = c_ST_TRAP;
            end
            c_ST_MEM_WRITE: begin
                if (mem_ready)           w_next = c_ST_FETCH;
                else if (w_wait_expired) w_next = c_ST_TRAP;
            end
            c_ST_EXECUTE: w_next = c_ST_R_WB;
            c_ST_ADDI_EX: w_next = c_ST_ADDI_WB;
            c_ST_MEM_WB,
            c_ST_R_WB,
            c_ST_ADDI_WB,
            c_ST_BRANCH,
            c_ST_JUMP:    w_next = c_ST_FETCH;
            c_ST_TRAP:    w_next = c_ST_TRAP;
            // Unused encodings are treated as a fault
            default:      w_next = c_ST_TRAP;
        endcase
    end

    // State, wait counter, sticky error and retirement counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_FETCH;
            r_wait  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (is_mem_state(r_state) && !mem_ready && (r_wait != c_wait_max)) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
            if ((w_next == c_ST_FETCH) && (r_state != c_ST_FETCH)) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            if (w_next == c_ST_TRAP) begin
                r_error <= 1'b1;
            end
        end
    end

    // Per-state datapath controls decoded from the registered state
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        pc_source       = c_PCSRC_ALU;
        i_or_d          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        w_reg_write     = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = c_SRCB_B;
        w_alu_op        = c_ALUOP_ADD;
        w_alu_en        = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = c_SRCB_FOUR;
                w_alu_en   = 1'b1;
                // PC and IR load only on the completing cycle of the fetch
                w_pc_write = mem_ready;
                w_ir_write = mem_ready;
            end
            c_ST_DECODE: begin
                alu_src_b = c_SRCB_IMM_SH;
                w_alu_en  = 1'b1;
            end
            c_ST_MEM_ADDR,
            c_ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                w_alu_en  = 1'b1;
            end
            c_ST_MEM_READ: begin
                w_mem_read = 1'b1;
                i_or_d     = 1'b1;
            end
            c_ST_MEM_WRITE: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
            end
            c_ST_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            c_ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_B;
                w_alu_op  = c_ALUOP_FUNCT;
                w_alu_en  = 1'b1;
            end
            c_ST_R_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            c_ST_ADDI_WB: begin
                w_reg_write = 1'b1;
            end
            c_ST_BRANCH: begin
                alu_src_a       = 1'b1;
                w_alu_op        = c_ALUOP_SUB;
                w_alu_en        = 1'b1;
                w_pc_write_cond = 1'b1;
                pc_source       = c_PCSRC_ALUOUT;
            end
            c_ST_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = c_PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // ALU control is zero outside states that use the ALU
    assign alu_control = w_alu_en ? w_dec_alu : 4'b0000;

    // Reset kills every request immediately, without waiting for a clock
    assign pc_write      = w_pc_write      & ~reset;
    assign pc_write_cond = w_pc_write_cond & ~reset;
    assign mem_read      = w_mem_read      & ~reset;
    assign mem_write     = w_mem_write     & ~reset;
    assign ir_write      = w_ir_write      & ~reset;
    assign reg_write     = w_reg_write     & ~reset;

    assign error       = r_error;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control. Stimulus pushes the
//               expected per-cycle state/controls/count; a negedge monitor
//               pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3;
    localparam logic [3:0] MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXECUTE = 4'd6, R_WB = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11;
    localparam logic [3:0] TRAP = 4'd12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, error;
    logic [1:0]  pc_source, alu_src_b;
    logic [3:0]  alu_control, state;
    logic [31:0] instr_count;

    multicycle_control #(.COUNT_WIDTH(32), .WAIT_LIMIT(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .error(error), .state(state), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic       err;
    } ctl_t;

    typedef struct {
        string       name;
        logic [3:0]  st;
        ctl_t        ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Hand-written expected controls per state
    function automatic ctl_t model(input logic [3:0] st, input logic rdy, input logic [3:0] alu);
        ctl_t c;
        c = '0;
        case (st)
            FETCH:     begin c.mr = 1'b1; c.srcb = 2'b01; c.alu = 4'b0010; c.pcw = rdy; c.irw = rdy; end
            DECODE:    begin c.srcb = 2'b11; c.alu = 4'b0010; end
            MEM_ADDR,
            ADDI_EX:   begin c.srca = 1'b1; c.srcb = 2'b10; c.alu = 4'b0010; end
            MEM_READ:  begin c.mr = 1'b1; c.iord = 1'b1; end
            MEM_WRITE: begin c.mw = 1'b1; c.iord = 1'b1; end
            MEM_WB:    begin c.rw = 1'b1; c.m2r = 1'b1; end
            EXECUTE:   begin c.srca = 1'b1; c.srcb = 2'b00; c.alu = alu; end
            R_WB:      begin c.rw = 1'b1; c.rdst = 1'b1; end
            ADDI_WB:   begin c.rw = 1'b1; end
            BRANCH:    begin c.srca = 1'b1; c.alu = 4'b0110; c.pcwc = 1'b1; c.pcs = 2'b01; end
            JUMP:      begin c.pcw = 1'b1; c.pcs = 2'b10; end
            TRAP:      begin c.err = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Monitor: compare DUT against the next expected record each cycle
    always @(negedge clock) begin
        exp_t e;
        ctl_t got;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_control, error};
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d", e.name, state, e.st);
            end
            n_checks++;
            if (got !== e.ctl) begin
                n_fail++;
                $display("FAIL %s controls: got %05h expected %05h", e.name, got, e.ctl);
            end
            n_checks++;
            if (instr_count !== e.cnt) begin
                n_fail++;
                $display("FAIL %s instr_count: got %0d expected %0d", e.name, instr_count, e.cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, queue expectation, advance to posedge+1
    task automatic cyc(input string nm, input logic [3:0] st, input logic rdy,
                       input logic [31:0] cnt, input logic [3:0] alu);
        exp_t e;
        mem_ready = rdy;
        e.name = nm;
        e.st   = st;
        e.ctl  = model(st, rdy, alu);
        e.cnt  = cnt;
        sb.push_back(e);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [31:0] ir);
        opcode = ir[31:26];
        funct  = ir[5:0];
    endtask

    // Reset asserted between edges; checks the asynchronous effect
    task automatic do_reset(input string nm);
        mem_ready = 1'b1;
        reset = 1'b1;
        #2;
        chk({nm, " rst state"}, {28'd0, state}, 32'd0);
        chk({nm, " rst count"}, instr_count, 32'd0);
        chk({nm, " rst error"}, {31'd0, error}, 32'd0);
        chk({nm, " rst enables"}, {26'd0, pc_write, pc_write_cond, ir_write, mem_write, reg_write, mem_read}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_r(input string nm, input logic [31:0] ir, input logic [3:0] alu, input logic [31:0] cnt);
        load(ir);
        cyc({nm, " fetch"}, FETCH, 1'b1, cnt, alu);
        cyc({nm, " decode"}, DECODE, 1'b1, cnt, alu);
        cyc({nm, " execute"}, EXECUTE, 1'b1, cnt, alu);
        cyc({nm, " r_wb"}, R_WB, 1'b1, cnt, alu);
    endtask

    initial begin
        logic [31:0] cnt;
        cnt = 0;
        #1;
        do_reset("init");

        // R-type instructions, one per supported funct
        run_r("add", 32'h012A4820, 4'b0010, cnt); cnt++;
        run_r("sub", 32'h012A4822, 4'b0110, cnt); cnt++;
        run_r("and", 32'h012A4824, 4'b0000, cnt); cnt++;
        run_r("or",  32'h012A4825, 4'b0001, cnt); cnt++;
        run_r("slt", 32'h012A482A, 4'b0111, cnt); cnt++;

        // lw with three stalled cycles in MEM_READ
        load(32'h8D320040);
        cyc("lw fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("lw decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("lw addr", MEM_ADDR, 1'b1, cnt, 4'd0);
        for (int i = 0; i < 3; i++) cyc("lw stall", MEM_READ, 1'b0, cnt, 4'd0);
        cyc("lw read", MEM_READ, 1'b1, cnt, 4'd0);
        cyc("lw wb", MEM_WB, 1'b1, cnt, 4'd0);
        cnt++;

        // beq taken and not taken: control identical, zero handled by datapath
        load(32'h11090003);
        zero = 1'b1;
        cyc("beq1 fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("beq1 decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("beq1 branch", BRANCH, 1'b1, cnt, 4'd0);
        cnt++;
        zero = 1'b0;
        cyc("beq0 fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("beq0 decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("beq0 branch", BRANCH, 1'b1, cnt, 4'd0);
        cnt++;

        // j, addi, sw with one stalled write cycle
        load(32'h08000010);
        cyc("j fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("j decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("j jump", JUMP, 1'b1, cnt, 4'd0);
        cnt++;
        load(32'h21290001);
        cyc("addi fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("addi decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("addi ex", ADDI_EX, 1'b1, cnt, 4'd0);
        cyc("addi wb", ADDI_WB, 1'b1, cnt, 4'd0);
        cnt++;
        load(32'hAD320040);
        cyc("sw fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("sw decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("sw addr", MEM_ADDR, 1'b1, cnt, 4'd0);
        cyc("sw stall", MEM_WRITE, 1'b0, cnt, 4'd0);
        cyc("sw write", MEM_WRITE, 1'b1, cnt, 4'd0);
        cnt++;

        // Unsupported opcode traps and holds
        load(32'hFC000000);
        cyc("bad op fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("bad op decode", DECODE, 1'b1, cnt, 4'd0);
        for (int i = 0; i < 20; i++) cyc("bad op trap", TRAP, 1'b1, cnt, 4'd0);
        do_reset("after bad op");
        cnt = 0;

        // Unsupported R-type funct traps
        load(32'h00000000);
        cyc("bad fn fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("bad fn decode", DECODE, 1'b1, cnt, 4'd0);
        for (int i = 0; i < 3; i++) cyc("bad fn trap", TRAP, 1'b1, cnt, 4'd0);
        do_reset("after bad fn");

        // Fetch stall beyond the wait limit traps
        for (int i = 0; i < 5; i++) cyc("limit stall", FETCH, 1'b0, cnt, 4'd0);
        cyc("limit trap", TRAP, 1'b0, cnt, 4'd0);
        cyc("limit trap hold", TRAP, 1'b1, cnt, 4'd0);
        do_reset("after limit");

        // Memory completes on the 4th cycle: no trap
        load(32'h012A4820);
        for (int i = 0; i < 3; i++) cyc("ok stall", FETCH, 1'b0, cnt, 4'd0);
        cyc("ok fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("ok decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("ok execute", EXECUTE, 1'b1, cnt, 4'b0010);
        cyc("ok r_wb", R_WB, 1'b1, cnt, 4'd0);
        cnt++;

        // Reset in the middle of a store aborts it without retiring
        load(32'hAD320040);
        cyc("abort fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("abort decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("abort addr", MEM_ADDR, 1'b1, cnt, 4'd0);
        cyc("abort stall", MEM_WRITE, 1'b0, cnt, 4'd0);
        #1;
        chk("abort mem_write before reset", {31'd0, mem_write}, 32'd1);
        chk("abort count before reset", instr_count, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort mem_write async", {31'd0, mem_write}, 32'd0);
        chk("abort state async", {28'd0, state}, 32'd0);
        chk("abort count async", instr_count, 32'd0);
        chk("abort error async", {31'd0, error}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cnt = 0;

        // Next store runs normally
        cyc("sw2 fetch", FETCH, 1'b1, cnt, 4'd0);
        cyc("sw2 decode", DECODE, 1'b1, cnt, 4'd0);
        cyc("sw2 addr", MEM_ADDR, 1'b1, cnt, 4'd0);
        cyc("sw2 write", MEM_WRITE, 1'b1, cnt, 4'd0);
        cnt++;
        cyc("final fetch", FETCH, 1'b0, cnt, 4'd0);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
